// File: rtl/param_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : param_reg_file
//  Purpose  : Parametrised register file with one write port and NUM_RD read
//             ports, write-through bypass, optional hard-wired zero register,
//             optional registered reads and a per-register busy scoreboard
//             used by decode to detect RAW hazards.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             rd_addr_i         - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//             rd_data_o         - packed read data, port i at [i*DATA_W +: DATA_W]
//             rd_busy_o         - per-port busy flag of the addressed register
//             wr_en_i/addr/data - write port; a write also clears busy
//             rsv_en_i/addr     - reservation port; sets busy
//             busy_vec_o        - registered scoreboard, bit n = busy[n]
//  Revision : 1.0 - initial release
// ============================================================================
module param_reg_file #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 0,
  parameter int SYNC_READ = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic [2**ADDR_W-1:0]     busy_vec_o
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              rsv_ok;

  // Writes and reservations aimed at the hard-wired zero register are dropped.
  assign wr_ok  = wr_en_i  && !(ZERO_EN && (wr_addr_i  == '0));
  assign rsv_ok = rsv_en_i && !(ZERO_EN && (rsv_addr_i == '0));

  // Reservation is applied after the write clear so that a same-address
  // collision leaves the register busy: a newer producer is in flight.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr_i]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr_i] <= wr_data_i;
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              zero;
      logic              hit;
      logic [DATA_W-1:0] data_d;

      assign addr = rd_addr_i[g*ADDR_W +: ADDR_W];
      assign zero = ZERO_EN && (addr == '0);
      assign hit  = wr_en_i && (wr_addr_i == addr);

      // Zero register takes priority over the bypass so r0 never leaks wr_data.
      assign data_d = zero ? '0 : (hit ? wr_data_i : regs_q[addr]);

      // A same-cycle write resolves the hazard; same-cycle reservations only
      // become visible once registered.
      assign rd_busy_o[g] = !zero && busy_q[addr] && !hit;

      if (SYNC_READ != 0) begin : g_sync
        logic [DATA_W-1:0] data_q;
        always_ff @(posedge clk) begin
          if (rst) data_q <= '0;
          else     data_q <= data_d;
        end
        assign rd_data_o[g*DATA_W +: DATA_W] = data_q;
      end else begin : g_comb
        assign rd_data_o[g*DATA_W +: DATA_W] = data_d;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_param_reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_reg_file
//  Purpose  : Self-checking bench for param_reg_file. Three instances cover the
//             default configuration, ZERO_REG=1 and SYNC_READ=1/NUM_RD=3.
//             Stimulus pushes expected values tagged with the cycle in which
//             they must hold; a monitor compares them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_reg_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: defaults
    logic        a_rst, a_wr_en, a_rsv_en;
    logic [7:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [3:0]  a_wr_addr, a_rsv_addr;
    logic [15:0] a_wr_data, a_busy;
    // instance Z: zero register
    logic        z_rst, z_wr_en, z_rsv_en;
    logic [7:0]  z_rd_addr;
    logic [31:0] z_rd_data;
    logic [1:0]  z_rd_busy;
    logic [3:0]  z_wr_addr, z_rsv_addr;
    logic [15:0] z_wr_data, z_busy;
    // instance S: registered reads, three ports
    logic        s_rst, s_wr_en, s_rsv_en;
    logic [11:0] s_rd_addr;
    logic [47:0] s_rd_data;
    logic [2:0]  s_rd_busy;
    logic [3:0]  s_wr_addr, s_rsv_addr;
    logic [15:0] s_wr_data, s_busy;

    param_reg_file u_a (
        .clk(clk), .rst(a_rst), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
        .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .rsv_en_i(a_rsv_en), .rsv_addr_i(a_rsv_addr), .busy_vec_o(a_busy));

    param_reg_file #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst(z_rst), .rd_addr_i(z_rd_addr), .rd_data_o(z_rd_data), .rd_busy_o(z_rd_busy),
        .wr_en_i(z_wr_en), .wr_addr_i(z_wr_addr), .wr_data_i(z_wr_data),
        .rsv_en_i(z_rsv_en), .rsv_addr_i(z_rsv_addr), .busy_vec_o(z_busy));

    param_reg_file #(.NUM_RD(3), .SYNC_READ(1)) u_s (
        .clk(clk), .rst(s_rst), .rd_addr_i(s_rd_addr), .rd_data_o(s_rd_data), .rd_busy_o(s_rd_busy),
        .wr_en_i(s_wr_en), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
        .rsv_en_i(s_rsv_en), .rsv_addr_i(s_rsv_addr), .busy_vec_o(s_busy));

    // signal selectors: 0/1/2 = A data/busy/vec, 3/4/5 = Z, 6/7/8 = S
    typedef struct {
        int          cyc;
        int          sig;
        int          idx;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input int dly, input int sig, input int idx, input logic [31:0] val,
                        input string nm);
        exp_t e;
        e.cyc = cyc + dly; e.sig = sig; e.idx = idx; e.val = val; e.nm = nm;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] get_act(input int sig, input int idx);
        logic [31:0] v;
        v = '0;
        case (sig)
            0: v[15:0] = a_rd_data[idx*16 +: 16];
            1: v[0]    = a_rd_busy[idx];
            2: v[15:0] = a_busy;
            3: v[15:0] = z_rd_data[idx*16 +: 16];
            4: v[0]    = z_rd_busy[idx];
            5: v[15:0] = z_busy;
            6: v[15:0] = s_rd_data[idx*16 +: 16];
            7: v[0]    = s_rd_busy[idx];
            8: v[15:0] = s_busy;
            default: v = 'x;
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == cyc) begin
                logic [31:0] act;
                act = get_act(sbq[i].sig, sbq[i].idx);
                n_vec++;
                if (act !== sbq[i].val) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", sbq[i].nm, act, sbq[i].val, cyc);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1; a_wr_en = 1; a_wr_addr = 4'd7; a_wr_data = 16'h1234;
        a_rsv_en = 0; a_rsv_addr = 0; a_rd_addr = 0;
        z_rst = 1; z_wr_en = 1; z_wr_addr = 4'd1; z_wr_data = 16'hBEEF;
        z_rsv_en = 1; z_rsv_addr = 4'd2; z_rd_addr = 0;
        s_rst = 1; s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0;
        s_rsv_en = 0; s_rsv_addr = 0; s_rd_addr = 0;
        tick(); tick();

        // ---- reset state ----
        a_rst = 0; z_rst = 0; s_rst = 0;
        a_wr_en = 0; z_wr_en = 0; z_rsv_en = 0;
        a_rd_addr = {4'd7, 4'd7};
        push(0, 0, 0, 32'h0, "a_rst_rd0");
        push(0, 0, 1, 32'h0, "a_rst_rd1");
        push(0, 2, 0, 32'h0, "a_rst_vec");
        push(0, 5, 0, 32'h0, "z_rst_vec");
        push(0, 6, 0, 32'h0, "s_rst_rd0");
        #1;
        n_vec++;
        if (a_busy !== 16'h0) begin
            n_err++;
            $display("FAIL d_a_rst_vec: got %h expected 0000", a_busy);
        end
        n_vec++;
        if (z_busy !== 16'h0) begin
            n_err++;
            $display("FAIL d_z_rst_vec: got %h expected 0000", z_busy);
        end

        // ---- A: write / read / bypass ----
        tick();
        a_wr_en = 1; a_wr_addr = 4'd7; a_wr_data = 16'h3099; a_rd_addr = {4'd7, 4'd3};
        push(0, 0, 0, 32'h0, "a_rd_r3");
        push(0, 0, 1, 32'h3099, "a_bypass_first");
        tick();
        a_wr_en = 0; a_rd_addr = {4'd3, 4'd7};
        push(0, 0, 0, 32'h3099, "a_rd_r7");
        tick();
        a_wr_en = 1; a_wr_data = 16'h808A; a_rd_addr = {4'd7, 4'd7};
        push(0, 0, 0, 32'h808A, "a_bypass0");
        push(0, 0, 1, 32'h808A, "a_bypass1");
        #1;
        n_vec++;
        if (a_rd_data[15:0] !== 16'h808A) begin
            n_err++;
            $display("FAIL d_a_bypass0: got %h expected 808a", a_rd_data[15:0]);
        end

        // ---- A: scoreboard ----
        tick();
        a_wr_en = 0; a_rsv_en = 1; a_rsv_addr = 4'd5; a_rd_addr = {4'd7, 4'd5};
        push(0, 1, 0, 32'h0, "a_rsv_same_cycle");
        push(0, 0, 1, 32'h808A, "a_r7_stored");
        tick();
        a_rsv_en = 0;
        push(0, 1, 0, 32'h1, "a_rd_busy5");
        push(0, 2, 0, 32'h0020, "a_vec5");
        #1;
        n_vec++;
        if (a_busy !== 16'h0020) begin
            n_err++;
            $display("FAIL d_a_vec5: got %h expected 0020", a_busy);
        end
        tick();
        a_wr_en = 1; a_wr_addr = 4'd5; a_wr_data = 16'hA173;
        push(0, 1, 0, 32'h0, "a_wr_resolves_busy");
        push(0, 0, 0, 32'hA173, "a_wr5_bypass");
        push(0, 2, 0, 32'h0020, "a_vec5_hold");
        tick();
        a_wr_en = 0;
        push(0, 2, 0, 32'h0, "a_vec5_clear");
        push(0, 0, 0, 32'hA173, "a_r5");

        // ---- A: collision and independent write/reserve ----
        tick();
        a_wr_en = 1; a_wr_addr = 4'd3; a_wr_data = 16'h5A5A;
        a_rsv_en = 1; a_rsv_addr = 4'd3; a_rd_addr = {4'd5, 4'd3};
        push(0, 1, 0, 32'h0, "a_coll_busy_now");
        push(1, 0, 0, 32'h5A5A, "a_coll_data");
        push(1, 1, 0, 32'h1, "a_coll_busy");
        push(1, 2, 0, 32'h0008, "a_coll_vec");
        tick();
        a_wr_addr = 4'd9; a_wr_data = 16'h0909; a_rsv_addr = 4'd10;
        push(1, 2, 0, 32'h0408, "a_indep_vec");
        tick();
        a_wr_en = 0; a_rsv_en = 0; a_rst = 1;
        push(1, 2, 0, 32'h0, "a_mid_rst_vec");
        push(1, 0, 0, 32'h0, "a_mid_rst_r3");
        tick();
        a_rst = 0;

        // ---- Z: zero register ----
        z_wr_en = 1; z_wr_addr = 4'd0; z_wr_data = 16'hFFFF;
        z_rsv_en = 1; z_rsv_addr = 4'd0; z_rd_addr = {4'd0, 4'd0};
        push(0, 3, 0, 32'h0, "z_r0_no_bypass");
        push(0, 4, 0, 32'h0, "z_r0_busy_now");
        #1;
        n_vec++;
        if (z_rd_data[15:0] !== 16'h0) begin
            n_err++;
            $display("FAIL d_z_r0_no_bypass: got %h expected 0000", z_rd_data[15:0]);
        end
        n_vec++;
        if (z_rd_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL d_z_r0_busy_now: got %b expected 0", z_rd_busy[0]);
        end
        tick();
        z_wr_en = 0; z_rsv_addr = 4'd2; z_rd_addr = {4'd0, 4'd1};
        push(0, 3, 0, 32'h0, "z_r1_after_rst");
        push(0, 3, 1, 32'h0, "z_r0_rd");
        push(0, 4, 1, 32'h0, "z_r0_busy");
        push(0, 5, 0, 32'h0, "z_vec0");
        push(1, 5, 0, 32'h0004, "z_vec2");
        tick();
        z_rsv_en = 0;

        // ---- S: registered reads, three ports ----
        s_wr_en = 1; s_wr_addr = 4'd1; s_wr_data = 16'h1111;
        tick();
        s_wr_addr = 4'd2; s_wr_data = 16'h2222;
        tick();
        s_wr_en = 0; s_rd_addr = {4'd1, 4'd2, 4'd1};
        push(0, 6, 0, 32'h0, "s_latency");
        push(1, 6, 0, 32'h1111, "s_p0_r1");
        push(1, 6, 1, 32'h2222, "s_p1_r2");
        push(1, 6, 2, 32'h1111, "s_p2_r1");
        tick();
        s_wr_en = 1; s_wr_addr = 4'd3; s_wr_data = 16'h3333;
        s_rsv_en = 1; s_rsv_addr = 4'd4; s_rd_addr = {4'd3, 4'd2, 4'd2};
        push(1, 6, 2, 32'h3333, "s_p2_bypass_captured");
        push(1, 6, 0, 32'h2222, "s_p0_r2");
        tick();
        s_wr_en = 0; s_rsv_en = 0; s_rd_addr = {4'd3, 4'd2, 4'd4}; s_rst = 1;
        push(0, 7, 0, 32'h1, "s_busy_comb");
        push(0, 8, 0, 32'h0010, "s_vec4");
        push(1, 6, 0, 32'h0, "s_mid_rst_p0");
        push(1, 6, 2, 32'h0, "s_mid_rst_p2");
        push(1, 8, 0, 32'h0, "s_mid_rst_vec");
        tick();
        s_rst = 0;
        #1;
        n_vec++;
        if (s_rd_data !== 48'h0) begin
            n_err++;
            $display("FAIL d_s_mid_rst_data: got %h expected 0", s_rd_data);
        end
        tick(); tick(); tick();

        foreach (sbq[i]) begin
            n_err++;
            $display("FAIL %s: never checked, expected %h at cycle %0d", sbq[i].nm, sbq[i].val, sbq[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
